// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with WAIT_CYCLES wait states
// in front of a one-cycle access to a little-endian 32-bit word array.
module dmem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic [7:0] sb_byte,
  input  logic [7:0] sh_byte,
  input  logic [7:0] sw_byte,
  output logic       be,
  output logic [7:0] wbyte
);
  always_comb begin
    be    = 1'b0;
    wbyte = sw_byte;
    case (size)
      2'b00: begin
        be    = (addr_lo == 2'(LANE));
        wbyte = sb_byte;
      end
      2'b01: begin
        be    = (addr_lo[1] == 1'(LANE / 2));
        wbyte = sh_byte;
      end
      default: begin
        be    = 1'b1;
        wbyte = sw_byte;
      end
    endcase
  end
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  typedef struct packed {
    logic                  we;
    logic [2:0]            funct;
    logic [ADDR_WIDTH+1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t          state;
  req_t            rq;
  logic [CW-1:0]   cnt;
  logic [3:0][7:0] mem [DEPTH];

  logic [3:0]            be;
  logic [3:0][7:0]       wbytes;
  logic                  funct_ok, align_ok, range_ok, req_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word, load_val;
  logic [7:0]            lb;
  logic [15:0]           lh;

  // Request legality is decided once, from the live request, at accept time.
  always_comb begin
    funct_ok = req_we ? (!req_funct[2] && req_funct[1:0] != 2'b11)
                      : (req_funct[1:0] != 2'b11 && !(req_funct[2] && req_funct[1]));
    align_ok = (req_funct[1:0] == 2'b00) ||
               (req_funct[1:0] == 2'b01 && !req_addr[0]) ||
               (req_funct[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
    range_ok = (req_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    req_err  = !(funct_ok && align_ok && range_ok);
  end

  always_comb begin
    idx  = rq.addr[ADDR_WIDTH+1:2];
    word = mem[idx];
    lb   = word[{rq.addr[1:0], 3'b000} +: 8];
    lh   = rq.addr[1] ? word[31:16] : word[15:0];
    case (rq.funct)
      3'b000:  load_val = {{24{lb[7]}}, lb};
      3'b001:  load_val = {{16{lh[15]}}, lh};
      3'b100:  load_val = {24'd0, lb};
      3'b101:  load_val = {16'd0, lh};
      default: load_val = word;
    endcase
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_lane #(.LANE(l)) u_lane (
      .size    (rq.funct[1:0]),
      .addr_lo (rq.addr[1:0]),
      .sb_byte (rq.wdata[7:0]),
      .sh_byte (rq.wdata[8*(l%2) +: 8]),
      .sw_byte (rq.wdata[8*l +: 8]),
      .be      (be[l]),
      .wbyte   (wbytes[l])
    );
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk)
    if (state == ACCESS && rq.we)
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][l] <= wbytes[l];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rq         <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rq        <= '{we: req_we, funct: req_funct,
                         addr: req_addr[ADDR_WIDTH+1:0], wdata: req_wdata};
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (req_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (WAIT_CYCLES > 0) begin
            state <= WAIT;
            cnt   <= CW'(WAIT_CYCLES);
          end else begin
            state <= ACCESS;
          end
        end
        // Count saturates at 1; that is the exit point.
        WAIT: if (cnt <= CW'(1)) state <= ACCESS;
              else               cnt   <= cnt - 1'b1;
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= rq.we ? 32'd0 : load_val;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory responder: the memory end of the core's load/store interface, servicing one request at a time. Accepts a request (write enable, funct3 width code, byte address, write data), waits a configurable number of cycles, performs the byte/half/word access on an internal little-endian word array, and returns read data or an error. Sits between the core's memory stage and storage, replacing the zero-wait data memory once multi-cycle memory is introduced.

## Interface

- Parameters:
  - ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
  - WAIT_CYCLES, 2: wait states before the access cycle; 0 is legal.
- Ports:
  - clk  in  1  single clock, all state on rising edge.
  - reset  in  1  asynchronous, active-high.
  - req_valid  in  1  request present.
  - req_ready  out  1  responder can accept; high only in IDLE.
  - req_we  in  1  1 = store, 0 = load.
  - req_funct  in  3  RISC-V funct3 width/sign code.
  - req_addr  in  32  byte address.
  - req_wdata  in  32  store data, LSB-aligned.
  - resp_valid  out  1  response present.
  - resp_ready  in  1  consumer takes response.
  - resp_rdata  out  32  load result, extended; 0 for stores and errors.
  - resp_err  out  1  request rejected: misaligned, out of range, or illegal funct.
  - busy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. Accept on req_valid & req_ready; latch we, funct, addr, wdata.
  - Error check at accept: error goes directly to RESP with resp_err=1, resp_rdata=0, memory untouched.
  - No error: go to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: down-counter loaded with WAIT_CYCLES at accept; move to ACCESS when it reaches 1.
- ACCESS, exactly one cycle; the only state that reads or writes the array. Then go to RESP.
- RESP: resp_valid=1; resp_rdata and resp_err stable until resp_ready. On resp_ready go to IDLE. resp_ready is ignored outside RESP.
- Funct decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code: error.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; otherwise error.
- Range: addr[31:ADDR_WIDTH+2] must be 0; otherwise error. Word index = addr[ADDR_WIDTH+1:2].
- Byte lanes, little-endian: lane = addr[1:0].
  - SB writes only that byte.
  - SH writes bytes addr[1]*2 and addr[1]*2+1.
  - Untouched bytes keep their value.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Store response: resp_valid with resp_rdata=0, resp_err=0.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0. Array contents are not reset and are retained across reset.
- Latency, valid request accepted at edge E: resp_valid rises after edge E+WAIT_CYCLES+1.
- Latency, error request accepted at edge E: resp_valid rises after edge E.
- Minimum request-to-request spacing: WAIT_CYCLES+3 cycles with resp_ready tied high; 2 cycles for errors.
- A store commits at the ACCESS edge. A load samples the array in ACCESS and registers the result at the same edge.
- Reset asserted in WAIT discards the pending store, with no array change. Reset in ACCESS races the commit edge: the store is undefined and the bench avoids this case. Reset in RESP drops the response.
- req_valid with req_ready low is ignored; the requester holds the request.
- The counter saturates and never wraps: WAIT is left exactly at count 1.

## Test plan

- Word store/load, WAIT_CYCLES=2: SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after accept.
- Byte lanes and extension: SW 0x20 = 0; SB 0x23 = 0x80; then LB 0x23 -> 0xFFFFFF80, LBU 0x23 -> 0x00000080, LW 0x20 -> 0x80000000.
- Halfword and errors:
  - SH 0x32 = 0x1234 then LHU 0x32 -> 0x00001234.
  - LH 0x31 -> resp_err 1, rdata 0, resp_valid 1 cycle after accept, memory unchanged.
  - LW 0x00001000 with ADDR_WIDTH=10 -> resp_err 1.
  - Funct 011 -> resp_err 1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata, err stable, req_ready 0, busy 1; release -> IDLE next cycle.
- Reset mid-WAIT: SW 0x40 = 0xA5A5A5A5 over existing 0x11111111, assert reset in WAIT -> outputs at reset values immediately; later LW 0x40 -> 0x11111111.
- WAIT_CYCLES=0: LW accepted at edge E -> resp_valid after edge E+1; back-to-back loads with resp_ready high complete every 3 cycles.
